// File: rtl/multi_channel_byte_packer.sv
// Per-channel byte-to-word assembler with flush of partial words and a sticky overflow flag.
// Build option: define PACKER_MSB_FIRST_EN for MSB-first byte ordering (default is LSB-first).
module multi_channel_byte_packer #(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned BYTE_W         = 8,
    parameter int unsigned BYTES_PER_WORD = 4,
    localparam int unsigned CNT_W         = $clog2(BYTES_PER_WORD + 1),
    localparam int unsigned WORD_W        = BYTE_W * BYTES_PER_WORD
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*BYTE_W-1:0]   in_data,
    input  logic [CHANNELS-1:0]          in_valid,
    input  logic [CHANNELS-1:0]          flush,
    output logic [CHANNELS*WORD_W-1:0]   out_data,
    output logic [CHANNELS-1:0]          out_valid,
    output logic [CHANNELS*CNT_W-1:0]    out_bytes,
    output logic [CHANNELS-1:0]          overflow
);

    if (WORD_W > 64) begin : gen_width_check
        $error("BYTES_PER_WORD*BYTE_W must not exceed 64");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : gen_ch
        logic [CNT_W-1:0]  cnt_q, cnt_d, held;
        logic [WORD_W-1:0] acc_q, acc_d, merged;
        logic [WORD_W-1:0] data_q, data_d;
        logic [CNT_W-1:0]  bytes_q, bytes_d;
        logic              valid_q, valid_d;
        logic              ovf_q, ovf_d;
        logic [BYTE_W-1:0] in_byte;
        logic              full;

        assign in_byte = in_data[c*BYTE_W +: BYTE_W];

        always_comb begin
            // Accumulator with this cycle's byte already placed in its slot.
            merged = acc_q;
            if (in_valid[c]) begin
                for (int s = 0; s < int'(BYTES_PER_WORD); s++) begin
                    if (cnt_q == CNT_W'(s)) begin
`ifdef PACKER_MSB_FIRST_EN
                        merged[(int'(BYTES_PER_WORD) - 1 - s)*BYTE_W +: BYTE_W] = in_byte;
`else
                        merged[s*BYTE_W +: BYTE_W] = in_byte;
`endif
                    end
                end
            end
            held = cnt_q + CNT_W'(in_valid[c]);
            full = (held == CNT_W'(BYTES_PER_WORD));

            cnt_d   = cnt_q;
            acc_d   = acc_q;
            data_d  = data_q;
            bytes_d = bytes_q;
            valid_d = 1'b0;
            ovf_d   = ovf_q;

            if (full || (flush[c] && held != '0)) begin
                data_d  = merged;
                bytes_d = held;
                valid_d = 1'b1;
                cnt_d   = '0;
                acc_d   = '0;
                // Flush coincided with the completing byte: nothing partial was left.
                if (full && flush[c]) begin
                    ovf_d = 1'b1;
                end
            end else if (in_valid[c]) begin
                cnt_d = held;
                acc_d = merged;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q   <= '0;
                acc_q   <= '0;
                data_q  <= '0;
                bytes_q <= '0;
                valid_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                acc_q   <= acc_d;
                data_q  <= data_d;
                bytes_q <= bytes_d;
                valid_q <= valid_d;
                ovf_q   <= ovf_d;
            end
        end

        assign out_data[c*WORD_W +: WORD_W] = data_q;
        assign out_bytes[c*CNT_W +: CNT_W]  = bytes_q;
        assign out_valid[c]                 = valid_q;
        assign overflow[c]                  = ovf_q;
    end

endmodule

// File: tb/tb_multi_channel_byte_packer.sv
// Self-checking bench for multi_channel_byte_packer: queue-style reference model plus literal checks.
// Honours PACKER_MSB_FIRST_EN the same way the design does.
module tb_multi_channel_byte_packer;
    localparam int CH  = 2;
    localparam int BW  = 8;
    localparam int BPW = 4;
    localparam int WW  = BW * BPW;
    localparam int CW  = $clog2(BPW + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [CH*BW-1:0]    in_data = '0;
    logic [CH-1:0]       in_valid = '0;
    logic [CH-1:0]       flush = '0;
    logic [CH*WW-1:0]    out_data;
    logic [CH-1:0]       out_valid;
    logic [CH*CW-1:0]    out_bytes;
    logic [CH-1:0]       overflow;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: bytes held per channel and the expected registered outputs.
    logic [BW-1:0] mbuf [CH][BPW];
    int            mcnt [CH];
    logic [WW-1:0] e_data [CH];
    int            e_bytes [CH];
    logic          e_valid [CH];
    logic          e_ovf [CH];

    multi_channel_byte_packer #(
        .CHANNELS      (CH),
        .BYTE_W        (BW),
        .BYTES_PER_WORD(BPW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .flush    (flush),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_bytes(out_bytes),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lit(input logic [31:0] lsb_first, input logic [31:0] msb_first);
`ifdef PACKER_MSB_FIRST_EN
        return msb_first;
`else
        return lsb_first;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_emit(input int c);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < mcnt[c]; i++) begin
`ifdef PACKER_MSB_FIRST_EN
            w[(BPW-1-i)*BW +: BW] = mbuf[c][i];
`else
            w[i*BW +: BW] = mbuf[c][i];
`endif
        end
        e_data[c]  = w;
        e_bytes[c] = mcnt[c];
        e_valid[c] = 1'b1;
        mcnt[c]    = 0;
    endtask

    // Apply one cycle of inputs, advance the model, then compare every output after the edge.
    task automatic step(input logic r, input logic [CH*BW-1:0] d, input logic [CH-1:0] v,
                        input logic [CH-1:0] f);
        rst = r; in_data = d; in_valid = v; flush = f;
        for (int c = 0; c < CH; c++) begin
            if (r) begin
                mcnt[c] = 0; e_data[c] = '0; e_bytes[c] = 0; e_valid[c] = 1'b0; e_ovf[c] = 1'b0;
            end else begin
                e_valid[c] = 1'b0;
                if (v[c]) begin
                    mbuf[c][mcnt[c]] = d[c*BW +: BW];
                    mcnt[c]++;
                end
                if (mcnt[c] == BPW) begin
                    if (f[c]) e_ovf[c] = 1'b1;
                    model_emit(c);
                end else if (f[c] && mcnt[c] > 0) begin
                    model_emit(c);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("ch%0d out_valid", c), 64'(out_valid[c]), 64'(e_valid[c]));
            chk($sformatf("ch%0d out_data", c), 64'(out_data[c*WW +: WW]), 64'(e_data[c]));
            chk($sformatf("ch%0d out_bytes", c), 64'(out_bytes[c*CW +: CW]), 64'(e_bytes[c]));
            chk($sformatf("ch%0d overflow", c), 64'(overflow[c]), 64'(e_ovf[c]));
        end
    endtask

    task automatic put0(input logic [7:0] b, input logic fl);
        step(1'b0, {8'h00, b}, 2'b01, {1'b0, fl});
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0);
    endtask

    initial begin
        step(1'b1, '0, '0, '0);
        step(1'b1, '0, '0, '0);
        chk("reset out_data", 64'(out_data), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);

        // Basic full word on ch0.
        put0(8'h11, 1'b0); put0(8'h22, 1'b0); put0(8'h33, 1'b0);
        chk("no early valid", 64'(out_valid), 64'd0);
        put0(8'h44, 1'b0);
        chk("word1 valid", 64'(out_valid), 64'b01);
        chk("word1 data", 64'(out_data[31:0]), 64'(lit(32'h44332211, 32'h11223344)));
        chk("word1 bytes", 64'(out_bytes[CW-1:0]), 64'd4);
        idle();
        chk("valid one cycle", 64'(out_valid[0]), 64'd0);
        chk("data held", 64'(out_data[31:0]), 64'(lit(32'h44332211, 32'h11223344)));

        // Zero bytes are real data.
        for (int i = 0; i < 4; i++) put0(8'h00, 1'b0);
        chk("zero word valid", 64'(out_valid[0]), 64'd1);
        chk("zero word data", 64'(out_data[31:0]), 64'd0);

        // Ch1 partial flush, then an empty flush.
        step(1'b0, {8'hAA, 8'h00}, 2'b10, 2'b00);
        step(1'b0, {8'hBB, 8'h00}, 2'b10, 2'b00);
        step(1'b0, '0, 2'b00, 2'b10);
        chk("flush valid", 64'(out_valid[1]), 64'd1);
        chk("flush data", 64'(out_data[WW +: WW]), 64'(lit(32'h0000BBAA, 32'hAABB0000)));
        chk("flush bytes", 64'(out_bytes[CW +: CW]), 64'd2);
        step(1'b0, '0, 2'b00, 2'b10);
        chk("empty flush", 64'(out_valid[1]), 64'd0);

        // Both channels at full rate.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, {8'(8'h81 + i), 8'(8'h01 + i)}, 2'b11, 2'b00);
            if (i == 3) begin
                chk("stream w0 valid", 64'(out_valid), 64'b11);
                chk("stream w0 ch0", 64'(out_data[31:0]), 64'(lit(32'h04030201, 32'h01020304)));
            end
        end
        chk("stream w1 valid", 64'(out_valid), 64'b11);
        chk("stream w1 ch0", 64'(out_data[31:0]), 64'(lit(32'h08070605, 32'h05060708)));
        chk("stream w1 ch1", 64'(out_data[WW +: WW]), 64'(lit(32'h88878685, 32'h85868788)));

        // Reset mid-word discards partial bytes.
        put0(8'h10, 1'b0); put0(8'h20, 1'b0);
        step(1'b1, '0, '0, '0);
        put0(8'h30, 1'b0); put0(8'h40, 1'b0); put0(8'h50, 1'b0);
        chk("post-reset no emit", 64'(out_valid), 64'd0);
        put0(8'h60, 1'b0);
        chk("post-reset word", 64'(out_data[31:0]), 64'(lit(32'h60504030, 32'h30405060)));

        // Single byte with flush on the same edge.
        put0(8'hAA, 1'b1);
        chk("byte+flush data", 64'(out_data[31:0]), 64'(lit(32'h000000AA, 32'hAA000000)));
        chk("byte+flush bytes", 64'(out_bytes[CW-1:0]), 64'd1);
        chk("no overflow yet", 64'(overflow), 64'd0);

        // Flush together with the completing byte sets overflow and still emits a full word.
        put0(8'h01, 1'b0); put0(8'h02, 1'b0); put0(8'h03, 1'b0); put0(8'h04, 1'b1);
        chk("overflow set", 64'(overflow), 64'b01);
        chk("overflow bytes", 64'(out_bytes[CW-1:0]), 64'd4);
        idle();
        chk("overflow sticky", 64'(overflow), 64'b01);

        // Randomized traffic.
        step(1'b1, '0, '0, '0);
        for (int n = 0; n < 3000; n++) begin
            logic [CH-1:0] v, f;
            for (int c = 0; c < CH; c++) begin
                v[c] = ($urandom_range(99) < 65);
                f[c] = ($urandom_range(99) < 15);
            end
            step(($urandom_range(199) == 0), CH*BW'($urandom), v, f);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/multi_channel_byte_packer.md
Name: multi_channel_byte_packer

Overview:
- Per-channel assembler: gathers BYTE_W-bit bytes into BYTES_PER_WORD-byte words for CHANNELS independent channels.
- Sits between byte-oriented sources (UART/keyboard/serial receivers) and 32-bit-class consumers (registers, display logic, game state).
- Valid-qualified input, so zero is a legal data byte; a byte is never used as an empty marker.
- Supports a flush of partial words, which are reported with a byte count.

Parameters:
- CHANNELS, 2, number of independent byte channels (1..8).
- BYTE_W, 8, width of one input byte in bits.
- BYTES_PER_WORD, 4, bytes per output word (2..8).
- CNT_W, $clog2(BYTES_PER_WORD+1), width of byte counters and out_bytes fields (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  CHANNELS*BYTE_W  channel c byte at [c*BYTE_W +: BYTE_W].
- in_valid  in  CHANNELS  bit c qualifies channel c byte; accepted every cycle it is high (no backpressure).
- flush  in  CHANNELS  bit c forces emission of channel c partial word.
- out_data  out  CHANNELS*BYTE_W*BYTES_PER_WORD  channel c word at [c*WORD_W +: WORD_W], WORD_W = BYTE_W*BYTES_PER_WORD.
- out_valid  out  CHANNELS  one-cycle pulse per emitted word.
- out_bytes  out  CHANNELS*CNT_W  number of valid bytes in the emitted word (BYTES_PER_WORD when full, 1..BYTES_PER_WORD-1 after flush).
- overflow  out  CHANNELS  sticky per-channel flag; cleared only by rst.

Behaviour:
- Reset (rst=1 at clk edge):
  - out_data=0, out_valid=0, out_bytes=0, overflow=0.
  - All internal byte counters and shift registers cleared.
- Channels are fully independent. No interaction between channels apart from the shared clk/rst.
- Per-channel state: counter cnt (0..BYTES_PER_WORD-1) and accumulation register acc (WORD_W).
- Byte accept, in_valid[c]=1:
  - Byte is written to slot cnt.
  - Default ordering: first byte lands in the least-significant slot [0 +: BYTE_W].
  - cnt increments.
- Word complete: when the accepted byte fills slot BYTES_PER_WORD-1, on the same edge:
  - out_data[c] <= full word (acc plus the new byte).
  - out_bytes[c] <= BYTES_PER_WORD.
  - out_valid[c] <= 1.
  - cnt <= 0 and acc <= 0.
- Latency: out_valid rises in the cycle immediately after the edge that captured the final byte, i.e. 1 clk.
- Back-to-back bytes at full rate are supported with no gaps. A new word may start on the same edge the previous word is emitted.
- out_data/out_bytes hold their last emitted value until the next emission. out_valid is high for exactly one cycle per word.
- Flush, flush[c]=1:
  - If cnt>0, or in_valid[c] is also high, emit on the same edge: acc (including any byte accepted on that same edge), unused slots zero, out_bytes = bytes held, out_valid=1, then cnt<=0, acc<=0.
  - If a byte and flush arrive together and that byte completes the word, it is a normal full emission, out_bytes=BYTES_PER_WORD.
  - If cnt=0 and no byte is present: no emission, out_valid stays 0.
- overflow[c] set when in_valid[c]=1 while rst=0 and out_valid[c] from the previous emission is still... not applicable (no backpressure). Instead, overflow[c] is set if flush[c] and in_valid[c] are both asserted while cnt=BYTES_PER_WORD-1 and the byte completes the word. This flags that the flush had nothing left to emit. The word is still emitted normally.
- Reset mid-word: partial bytes are discarded and no emission occurs.
- Width rule: BYTES_PER_WORD*BYTE_W must not exceed 64. Violations are a compile-time error (generate-time check).

Optional Feature:
- Macro PACKER_MSB_FIRST_EN.
- Defined: first accepted byte lands in the most-significant slot [WORD_W-BYTE_W +: BYTE_W], and later bytes fill downward. A flushed partial word is left-aligned, with zeros in the low slots.
- Undefined: LSB-first ordering as in Behaviour, and a flushed partial word is right-aligned.
- out_valid, out_bytes, latency and overflow are identical in both builds.

Test Plan:
- Defaults, ch0 bytes 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle later out_valid[0]=1, out_data ch0=0x44332211, out_bytes=4, ch1 out_valid=0.
- Ch0 bytes 0x00,0x00,0x00,0x00 -> out_data ch0=0x00000000 with out_valid=1 (zero bytes are counted).
- Ch1 bytes 0xAA,0xBB then flush[1] alone -> out_data ch1=0x0000BBAA, out_bytes=2; a second flush with no bytes -> no out_valid.
- Both channels streaming 8 bytes simultaneously at full rate (ch0 0x01..0x08, ch1 0x81..0x88) -> two pulses per channel, ch0 words 0x04030201 then 0x08070605, with no gap cycles.
- Ch0 bytes 0x10,0x20 then rst for 1 cycle, then 0x30,0x40,0x50,0x60 -> single word 0x60504030, with no emission from the discarded bytes.
- PACKER_MSB_FIRST_EN build: bytes 0x11,0x22,0x33,0x44 -> 0x11223344; bytes 0xAA plus flush -> 0xAA000000, out_bytes=1.
